// File: rtl/dsi_lane_distributor_if.sv
// DSI lane distributor word-stream bundle.
// The master offers words, the distributor returns ready.
interface dsi_lane_distributor_if;
  logic        iface_write_rqst;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_lp;
  logic        iface_write_last;
  logic        iface_data_rqst;

  modport master (
    output iface_write_rqst,
    output iface_write_data,
    output iface_write_strb,
    output iface_write_lp,
    output iface_write_last,
    input  iface_data_rqst
  );

  modport slave (
    input  iface_write_rqst,
    input  iface_write_data,
    input  iface_write_strb,
    input  iface_write_lp,
    input  iface_write_last,
    output iface_data_rqst
  );
endinterface

// File: rtl/dsi_lane_distributor.sv
// DSI lane distributor: stripes packet bytes round-robin
// over 1-4 lane FIFOs, one byte per lane per cycle.
module dsi_lane_distributor (
  input  logic                   clk_phy,
  input  logic                   rst_n,
  input  logic [2:0]             reg_lanes_number,
  dsi_lane_distributor_if.slave  wr,
  output logic [35:0]            lanes_fifo_wdata,
  output logic [3:0]             lanes_fifo_write,
  input  logic [3:0]             lanes_fifo_full,
  output logic                   dist_active,
  output logic                   packet_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_WORD
  } state_t;

  state_t     state_q;
  logic [7:0] q_q [4];
  logic [2:0] rem_q;
  logic [2:0] n_q;
  logic [1:0] ptr_q;
  logic       lp_q;
  logic       last_q;
  logic       active_q;
  logic       done_q;

  logic [2:0]  b;
  logic [2:0]  sum;
  logic [2:0]  psum;
  logic [2:0]  idx;
  logic [3:0]  mask;
  logic [35:0] data;
  logic        issue;
  logic        fin;
  logic        accept;
  logic        end_issue;
  logic        empty_end;
  logic        first;
  logic [2:0]  n_eff;
  logic [2:0]  cnt;
  logic [7:0]  ld [4];
  logic [7:0]  sh [4];

  // Beat formation: queue byte j goes to lane (ptr+j) mod N.
  always_comb begin
    b    = (rem_q < n_q) ? rem_q : n_q;
    mask = '0;
    data = '0;
    sum  = '0;
    for (int j = 0; j < 4; j++) begin
      sum = {1'b0, ptr_q} + 3'(j);
      if (sum >= n_q) sum = sum - n_q;
      if (3'(j) < b) begin
        mask[sum[1:0]] = 1'b1;
        data[int'(sum[1:0])*9 +: 9] = {lp_q, q_q[j]};
      end
    end
    issue = (rem_q != 3'd0) &&
            ((mask & lanes_fifo_full) == 4'd0);
  end

  // Next pointer and queue contents after a beat issues.
  always_comb begin
    psum = {1'b0, ptr_q} + b;
    if (psum >= n_q) psum = psum - n_q;
    idx = '0;
    for (int j = 0; j < 4; j++) begin
      idx   = 3'(j) + b;
      sh[j] = (idx < 3'd4) ? q_q[idx[1:0]] : 8'd0;
    end
  end

  // Compact the enabled bytes of the incoming word.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < 4; k++) ld[k] = '0;
    for (int k = 0; k < 4; k++) begin
      if (wr.iface_write_strb[k]) begin
        ld[cnt[1:0]] = wr.iface_write_data[k*8 +: 8];
        cnt = cnt + 3'd1;
      end
    end
  end

  // Clamp the programmed lane count into 1..4.
  always_comb begin
    n_eff = 3'd4;
    unique case (1'b1)
      reg_lanes_number <= 3'd1: n_eff = 3'd1;
      reg_lanes_number == 3'd2: n_eff = 3'd2;
      reg_lanes_number == 3'd3: n_eff = 3'd3;
      default:                  n_eff = 3'd4;
    endcase
  end

  assign lanes_fifo_write = issue ? mask : 4'd0;
  assign lanes_fifo_wdata = issue ? data : 36'd0;

  assign fin       = issue && (b == rem_q);
  assign wr.iface_data_rqst = (rem_q == 3'd0) || fin;
  assign accept    = wr.iface_write_rqst &&
                     wr.iface_data_rqst;
  assign end_issue = fin && last_q;
  assign empty_end = accept &&
                     (wr.iface_write_strb == 4'd0) &&
                     wr.iface_write_last;
  // A packet that ends this cycle frees the slot for a new one.
  assign first     = (state_q == IDLE) || end_issue;

  assign dist_active = active_q;
  assign packet_done = done_q;

  // Holding register, lane pointer and packet FSM.
  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= 3'd0;
      n_q      <= 3'd1;
      ptr_q    <= 2'd0;
      lp_q     <= 1'b0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < 4; k++) q_q[k] <= 8'd0;
    end else begin
      done_q <= end_issue || empty_end;
      if (issue) begin
        rem_q <= rem_q - b;
        ptr_q <= psum[1:0];
        for (int k = 0; k < 4; k++) q_q[k] <= sh[k];
      end
      if (accept) begin
        for (int k = 0; k < 4; k++) q_q[k] <= ld[k];
        rem_q  <= cnt;
        lp_q   <= wr.iface_write_lp;
        last_q <= wr.iface_write_last;
        if (first) n_q <= n_eff;
      end
      if (end_issue || empty_end) ptr_q <= 2'd0;
      if (empty_end) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
      end else if (accept) begin
        state_q  <= (cnt != 3'd0) ? LOAD : WAIT_WORD;
        active_q <= 1'b1;
      end else if (end_issue) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
      end else if (fin) begin
        state_q  <= WAIT_WORD;
      end
    end
  end

endmodule
